// File: rtl/seq_detect_ctrl.sv
// Word-level controller for a serial "10110" Moore detector: clears the detector, shifts each word MSB-first, counts matches.
// Optional sticky threshold interrupt is enabled by defining SEQ_CTRL_IRQ_EN.
module seq_detect_ctrl #(
    parameter int W      = 8,
    parameter int CW     = $clog2(W + 1)
`ifdef SEQ_CTRL_IRQ_EN
    ,
    parameter int THRESH = 1
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          det_j,
    output logic          det_rst,
    input  logic          det_w,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_cnt
`ifdef SEQ_CTRL_IRQ_EN
    ,
    input  logic          irq_clr,
    output logic          irq
`endif
);

    localparam int BW = $clog2(W);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shift;
    logic [BW-1:0]   r_bit_cnt;
    logic [CW-1:0]   r_match_cnt;
    logic            r_in_ready;
    logic            r_det_j;
    logic            r_det_rst;
    logic            r_busy;
    logic            r_done;
    logic [CW-1:0]   w_cnt_inc;
    logic [CW-1:0]   w_cnt_next;

    // Count value including the detector sample taken at this edge.
    always_comb begin
        w_cnt_inc  = r_match_cnt + CW'(1);
        w_cnt_next = r_match_cnt;
        if (det_w) begin
            w_cnt_next = w_cnt_inc;
        end else begin
            w_cnt_next = r_match_cnt;
        end
    end

    // Control FSM; det_j is pre-loaded one edge ahead so it is a clean register output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_match_cnt <= '0;
            r_in_ready  <= 1'b1;
            r_det_j     <= 1'b0;
            r_det_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_det_rst <= 1'b0;
                    r_det_j   <= 1'b0;
                    if (in_valid) begin
                        r_shift     <= in_data;
                        r_match_cnt <= '0;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_det_rst   <= 1'b1;
                        r_state     <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_det_rst <= 1'b0;
                    r_det_j   <= r_shift[W-1];
                    r_shift   <= {r_shift[W-2:0], 1'b0};
                    r_bit_cnt <= '0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_match_cnt <= w_cnt_next;
                    r_bit_cnt   <= r_bit_cnt + BW'(1);
                    if (r_bit_cnt == BIT_LAST) begin
                        r_det_j <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_det_j <= r_shift[W-1];
                        r_shift <= {r_shift[W-2:0], 1'b0};
                    end
                end
                S_DRAIN: begin
                    r_match_cnt <= w_cnt_next;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_det_j    <= 1'b0;
                    r_det_rst  <= 1'b1;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_CTRL_IRQ_EN
    logic r_irq;
    logic w_irq_set;

    // Threshold test uses the final count, so irq rises together with done.
    always_comb begin
        w_irq_set = 1'b0;
        if (r_state == S_DRAIN) begin
            w_irq_set = (int'(w_cnt_next) >= THRESH);
        end else begin
            w_irq_set = 1'b0;
        end
    end

    // Sticky flag; a coincident clear loses to a new set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq;
        end
    end

    assign irq = r_irq;
`endif

    assign in_ready  = r_in_ready;
    assign det_j     = r_det_j;
    assign det_rst   = r_det_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign match_cnt = r_match_cnt;

endmodule
